// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end. It combines the PC generator, the
// redirect arbiter and a DEPTH-entry prefetch FIFO of {pc_plus4, instr} pairs, and
// hands entries to ID through a valid/ready handshake. Instruction memory has a
// fixed read latency of one cycle.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   exc, irq                      vector redirect requests (EXC_VEC / INT_VEC)
//   br_/jr_/j_taken, *_target     branch / jr / jump redirect requests and targets
//   imem_req, imem_addr           fetch request this cycle, fetch address
//   imem_rdata                    instruction, valid the cycle after imem_req
//   out_valid, out_ready          queue head handshake towards ID
//   out_pc_plus4, out_instr       queue head payload
//   sel_conflict                  registered pulse: >1 redirect request last cycle
//
// imem_req is combinational: a redirect must suppress the request in the same
// cycle, and a pop in the current cycle frees a slot for an issue in that cycle.
module if_prefetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter logic [XLEN-1:0] INT_VEC  = 32'h8000_0004,
    parameter logic [XLEN-1:0] EXC_VEC  = 32'h8000_0008
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc,
    input  logic            irq,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jr_taken,
    input  logic [XLEN-1:0] jr_target,
    input  logic            j_taken,
    input  logic [XLEN-1:0] j_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [XLEN-1:0] out_instr,
    output logic            sel_conflict
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = CW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_addr;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [XLEN-1:0] pc4_mem   [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [2:0]      req_cnt;
    logic            pop;
    logic            push;
    logic [OW-1:0]   occ;

    // Low field increments and wraps; the kernel bit (MSB) is preserved.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] p);
        pc_plus4 = {p[XLEN-1], p[XLEN-2:0] + (XLEN-1)'(4)};
    endfunction

    // Redirect arbiter: exc > irq > br > jr > j.
    always_comb begin
        redirect    = exc | irq | br_taken | jr_taken | j_taken;
        req_cnt     = 3'(exc) + 3'(irq) + 3'(br_taken) + 3'(jr_taken) + 3'(j_taken);
        redirect_pc = j_target;
        if (exc)           redirect_pc = {1'b1, EXC_VEC[XLEN-2:0]};
        else if (irq)      redirect_pc = {1'b1, INT_VEC[XLEN-2:0]};
        else if (br_taken) redirect_pc = br_target;
        else if (jr_taken) redirect_pc = jr_target;
    end

    // Issue rule: occupancy after this cycle's push/pop must leave room for one more.
    always_comb begin
        pop      = (count != '0) & out_ready;
        push     = inflight & ~redirect;
        occ      = OW'(count) + OW'(inflight) - OW'(pop);
        imem_req = rst_n & ~redirect & (occ < OW'(DEPTH));
    end

    assign imem_addr    = fetch_pc;
    assign out_valid    = (count != '0);
    assign out_pc_plus4 = pc4_mem[rd_ptr];
    assign out_instr    = instr_mem[rd_ptr];

    // Fetch PC, in-flight tracking, FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc      <= RESET_PC;
            inflight_addr <= '0;
            inflight      <= 1'b0;
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            sel_conflict  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc4_mem[i]   <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            sel_conflict <= (req_cnt > 3'd1);
            if (redirect) begin
                // A pop this cycle is simply absorbed by clearing the queue.
                fetch_pc <= redirect_pc;
                inflight <= 1'b0;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (imem_req) begin
                    fetch_pc      <= pc_plus4(fetch_pc);
                    inflight_addr <= fetch_pc;
                end
                inflight <= imem_req;
                if (push) begin
                    pc4_mem[wr_ptr]   <= pc_plus4(inflight_addr);
                    instr_mem[wr_ptr] <= imem_rdata;
                    wr_ptr            <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule
